eth_intr_coalesce_ctrl: RTL and testbench
=========================================

// Module: eth_intr_coalesce_ctrl
// PURPOSE
//  Interrupt controller for the Ethernet MAC's single interrupt line (wb_intr).
//  - Latches NSRC MAC event sources into a pending register; the CPU clears bits by write-1-to-clear.
//  - Applies a mask, coalesces events by count threshold or timeout, and drives wb_intr.
//  - Sits between the MAC core's event outputs and the host; programmed over a Wishbone slave port.
// PARAMETERS
//  NSRC     7   number of event sources (TXB,TXE,RXB,RXE,BUSY,TXC,RXC), 1..32
//  CNT_W    8   coalescing event-counter width (threshold field width)
//  TMO_W    16  coalescing timeout-timer width
// PORTS
//  wb_clk    in   1      single clock
//  wb_rst    in   1      synchronous, active-high reset
//  evt_i     in   NSRC   level event sources from MAC; a rising edge is one event
//  wb_adr_i  in   4      byte address; bits [3:2] used
//  wb_dat_i  in   32     write data
//  wb_dat_o  out  32     read data, valid with wb_ack_o
//  wb_we_i   in   1      write enable
//  wb_stb_i  in   1      strobe
//  wb_cyc_i  in   1      cycle
//  wb_ack_o  out  1      single-cycle ack
//  wb_intr   out  1      interrupt to host, level, active-high
// BEHAVIOUR
//  Reset: wb_intr=0, wb_ack_o=0, wb_dat_o=0, PEND=0, MASK=0, THRESH=1, TIMEOUT=0, cnt=0, timer=0, state=IDLE,
//   edge-detect history=0. All resets synchronous on wb_clk while wb_rst=1.
//  Registers: 0x0 PEND (R/W1C), 0x4 MASK (RW), 0x8 COAL {TIMEOUT[TMO_W+7:8], THRESH[7:0]},
//   0xC STAT {state[17:16], cnt[7:0]} (RO). Unused bits read 0; writes to STAT are ignored.
//  Bus: wb_ack_o=1 exactly one cycle after a cycle with cyc&stb&!ack; no back-to-back ack (2-cycle min).
//   Write takes effect on the ack cycle; read data is registered and valid on the ack cycle.
//  Events: new = evt_i & ~evt_q (evt_q = evt_i delayed one cycle). PEND |= new every cycle.
//   Same-bit W1C and new event in one cycle: set wins (bit stays 1).
//  cnt += popcount(new & MASK), saturating at 2^CNT_W-1; cleared on entering IDLE.
//  FSM:
//   IDLE   : (PEND&MASK)!=0 -> ACCUM, timer loaded with TIMEOUT.
//   ACCUM  : cnt>=THRESH, or TIMEOUT!=0 && timer==1 -> ASSERT; (PEND&MASK)==0 (cleared/masked) -> IDLE.
//            timer decrements once per cycle, stops at 0.
//   ASSERT : wb_intr=1 (registered; rises the cycle after ASSERT is entered). (PEND&MASK)==0 -> IDLE.
//            New events keep it asserted.
//  THRESH 0 or 1: ASSERT on the cycle after entering ACCUM. TIMEOUT=0: timer disabled, threshold only.
//  Unmasking an already-pending bit in IDLE starts ACCUM. It does not add to cnt.
//  Latency with THRESH=1: event edge at cycle N -> PEND at N+1 -> ACCUM N+2 -> ASSERT N+3 -> wb_intr N+4.
//  THRESH write below the current cnt while in ACCUM: ASSERT next cycle.
//  wb_rst asserted mid-operation: everything returns to reset values; a pending bus cycle gets no ack.
// STRUCTURE
//  eth_intr_pkg: typedef enum logic[1:0] {IDLE,ACCUM,ASSERT} intr_state_t; register offset
//   localparams (PEND/MASK/COAL/STAT); COAL/STAT field bit positions.
//  Sub-module eth_intr_wb_regs: Wishbone decode, ack generation, MASK/COAL storage, read mux, W1C pulse
//   output. Edge detect, PEND, counter, timer and FSM live in the top.
// TESTING
//  1. Reset, MASK=0x7F, THRESH=1, pulse evt_i[0] -> PEND=0x01; wb_intr rises 4 cycles after the edge;
//     write PEND=0x01 -> wb_intr drops; state=IDLE.
//  2. THRESH=3, TIMEOUT=0, edges on bits 1,2 -> no intr, STAT.cnt=2; third edge (bit 3) -> intr.
//  3. THRESH=8, TIMEOUT=20, one edge -> intr asserts 20 cycles after ACCUM entry; cnt=1.
//  4. MASK=0, edge on bit 4 -> PEND=0x10, no intr; write MASK=0x10 -> ACCUM -> intr.
//  5. W1C of bit 2 in the same cycle as a new bit-2 edge -> PEND[2] stays 1, intr stays asserted.
//  6. wb_rst pulsed while in ASSERT with a bus read outstanding -> wb_intr=0, all regs reset, no ack.

Source files
------------

// File: rtl/eth_intr_pkg.sv
// Shared types and register map for the Ethernet MAC interrupt coalescing controller.
package eth_intr_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCUM  = 2'd1,
      ASSERT = 2'd2
   } intr_state_t;

   // Word offsets, decoded from wb_adr_i[3:2]
   localparam logic [1:0] REG_PEND = 2'd0;
   localparam logic [1:0] REG_MASK = 2'd1;
   localparam logic [1:0] REG_COAL = 2'd2;
   localparam logic [1:0] REG_STAT = 2'd3;

   // Field positions inside COAL and STAT
   localparam int unsigned COAL_THRESH_LSB = 0;
   localparam int unsigned COAL_TMO_LSB    = 8;
   localparam int unsigned STAT_CNT_LSB    = 0;
   localparam int unsigned STAT_STATE_LSB  = 16;

endpackage

// File: rtl/eth_intr_wb_regs.sv
// Wishbone slave: address decode, single-cycle ack, MASK/COAL storage, read mux, W1C pulse.
module eth_intr_wb_regs
   import eth_intr_pkg::*;
#(
   parameter int unsigned NSRC  = 7,
   parameter int unsigned CNT_W = 8,
   parameter int unsigned TMO_W = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [3:0]       i_adr,
   input  logic [31:0]      i_dat,
   input  logic             i_we,
   input  logic             i_stb,
   input  logic             i_cyc,
   output logic [31:0]      o_dat,
   output logic             o_ack,
   input  logic [NSRC-1:0]  i_pend,
   input  intr_state_t      i_state,
   input  logic [CNT_W-1:0] i_cnt,
   output logic [NSRC-1:0]  o_mask,
   output logic [CNT_W-1:0] o_thresh,
   output logic [TMO_W-1:0] o_timeout,
   output logic [NSRC-1:0]  o_w1c
);

   logic             r_ack;
   logic [31:0]      r_dat;
   logic [NSRC-1:0]  r_mask;
   logic [CNT_W-1:0] r_thresh;
   logic [TMO_W-1:0] r_timeout;
   logic             w_req;
   logic             w_wr;
   logic [31:0]      w_rdata;
   logic             w_unused;

   // Request cycle issues the ack; the write itself lands on the ack cycle.
   assign w_req    = i_cyc & i_stb & ~r_ack;
   assign w_wr     = i_cyc & i_stb & i_we & r_ack;
   assign w_unused = ^{i_adr[1:0], i_dat};

   // Read mux, sampled on the request cycle so data is stable during ack
   always_comb begin
      w_rdata = '0;
      case (i_adr[3:2])
         REG_PEND: w_rdata[NSRC-1:0] = i_pend;
         REG_MASK: w_rdata[NSRC-1:0] = r_mask;
         REG_COAL: begin
            w_rdata[COAL_THRESH_LSB +: CNT_W] = r_thresh;
            w_rdata[COAL_TMO_LSB +: TMO_W]    = r_timeout;
         end
         default: begin
            w_rdata[STAT_CNT_LSB +: CNT_W] = i_cnt;
            w_rdata[STAT_STATE_LSB +: 2]   = i_state;
         end
      endcase
   end

   // Ack, read-data and control register updates
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_ack     <= 1'b0;
         r_dat     <= '0;
         r_mask    <= '0;
         r_thresh  <= CNT_W'(1);
         r_timeout <= '0;
      end else begin
         r_ack <= w_req;
         if (w_req) begin
            r_dat <= w_rdata;
         end
         if (w_wr && (i_adr[3:2] == REG_MASK)) begin
            r_mask <= i_dat[NSRC-1:0];
         end
         if (w_wr && (i_adr[3:2] == REG_COAL)) begin
            r_thresh  <= i_dat[COAL_THRESH_LSB +: CNT_W];
            r_timeout <= i_dat[COAL_TMO_LSB +: TMO_W];
         end
      end
   end

   assign o_ack     = r_ack;
   assign o_dat     = r_dat;
   assign o_mask    = r_mask;
   assign o_thresh  = r_thresh;
   assign o_timeout = r_timeout;
   assign o_w1c     = (w_wr && (i_adr[3:2] == REG_PEND)) ? i_dat[NSRC-1:0] : '0;

endmodule

// File: rtl/eth_intr_coalesce_ctrl.sv
// Interrupt controller for the MAC's wb_intr: edge-latched pending bits, masking,
// and count/timeout coalescing before the interrupt line is raised.
module eth_intr_coalesce_ctrl
   import eth_intr_pkg::*;
#(
   parameter int unsigned NSRC  = 7,
   parameter int unsigned CNT_W = 8,
   parameter int unsigned TMO_W = 16
) (
   input  logic            wb_clk,
   input  logic            wb_rst,
   input  logic [NSRC-1:0] evt_i,
   input  logic [3:0]      wb_adr_i,
   input  logic [31:0]     wb_dat_i,
   output logic [31:0]     wb_dat_o,
   input  logic            wb_we_i,
   input  logic            wb_stb_i,
   input  logic            wb_cyc_i,
   output logic            wb_ack_o,
   output logic            wb_intr
);

   localparam int unsigned INC_W = $clog2(NSRC + 1);
   localparam int unsigned SUM_W = ((CNT_W > INC_W) ? CNT_W : INC_W) + 1;

   logic [NSRC-1:0]  r_evt_q;
   logic [NSRC-1:0]  r_pend;
   logic [CNT_W-1:0] r_cnt;
   logic [TMO_W-1:0] r_timer;
   intr_state_t      r_state;
   logic             r_intr;

   logic [NSRC-1:0]  w_new;
   logic [NSRC-1:0]  w_new_m;
   logic [NSRC-1:0]  w_w1c;
   logic [NSRC-1:0]  w_mask;
   logic [CNT_W-1:0] w_thresh;
   logic [TMO_W-1:0] w_timeout;
   logic             w_active;
   logic             w_thr_hit;
   logic             w_tmo_hit;
   logic [INC_W-1:0] w_inc;
   logic [SUM_W-1:0] w_sum;
   logic [CNT_W-1:0] w_cnt_sat;
   intr_state_t      w_state_nxt;

   eth_intr_wb_regs #(
      .NSRC  (NSRC),
      .CNT_W (CNT_W),
      .TMO_W (TMO_W)
   ) u_regs (
      .i_clk     (wb_clk),
      .i_rst     (wb_rst),
      .i_adr     (wb_adr_i),
      .i_dat     (wb_dat_i),
      .i_we      (wb_we_i),
      .i_stb     (wb_stb_i),
      .i_cyc     (wb_cyc_i),
      .o_dat     (wb_dat_o),
      .o_ack     (wb_ack_o),
      .i_pend    (r_pend),
      .i_state   (r_state),
      .i_cnt     (r_cnt),
      .o_mask    (w_mask),
      .o_thresh  (w_thresh),
      .o_timeout (w_timeout),
      .o_w1c     (w_w1c)
   );

   assign w_new     = evt_i & ~r_evt_q;
   assign w_new_m   = w_new & w_mask;
   assign w_active  = |(r_pend & w_mask);
   // Threshold of 0 or 1 means "fire on the first ACCUM cycle", even with cnt still 0.
   assign w_thr_hit = (w_thresh <= CNT_W'(1)) || (r_cnt >= w_thresh);
   assign w_tmo_hit = (w_timeout != '0) && (r_timer == TMO_W'(1));

   // Saturating add of newly seen masked events
   always_comb begin
      w_inc = '0;
      for (int i = 0; i < NSRC; i++) begin
         w_inc = w_inc + INC_W'(w_new_m[i]);
      end
      w_sum     = SUM_W'(r_cnt) + SUM_W'(w_inc);
      w_cnt_sat = (w_sum > SUM_W'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
   end

   // Next-state logic; losing all masked pending bits takes priority over firing
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (w_active) w_state_nxt = ACCUM;
         end
         ACCUM: begin
            if (!w_active)                   w_state_nxt = IDLE;
            else if (w_thr_hit || w_tmo_hit) w_state_nxt = ASSERT;
         end
         ASSERT: begin
            if (!w_active) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // State, pending, counter, timer and interrupt registers
   always_ff @(posedge wb_clk) begin
      if (wb_rst) begin
         r_evt_q <= '0;
         r_pend  <= '0;
         r_cnt   <= '0;
         r_timer <= '0;
         r_state <= IDLE;
         r_intr  <= 1'b0;
      end else begin
         r_evt_q <= evt_i;
         // A new edge on a bit being cleared keeps the bit set
         r_pend  <= (r_pend & ~w_w1c) | w_new;
         if ((r_state != IDLE) && (w_state_nxt == IDLE)) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= w_cnt_sat;
         end
         if ((r_state == IDLE) && (w_state_nxt == ACCUM)) begin
            r_timer <= w_timeout;
         end else if ((r_state == ACCUM) && (r_timer != '0)) begin
            r_timer <= r_timer - TMO_W'(1);
         end
         r_state <= w_state_nxt;
         r_intr  <= (r_state == ASSERT);
      end
   end

   assign wb_intr = r_intr;

endmodule

// File: tb/tb_eth_intr_coalesce_ctrl.sv
// Bench for eth_intr_coalesce_ctrl: directed scenarios plus randomized traffic against a
// behavioural model of the interrupt controller's register and coalescing rules.
module tb_eth_intr_coalesce_ctrl;

   localparam int unsigned S_IDLE   = 0;
   localparam int unsigned S_ACCUM  = 1;
   localparam int unsigned S_ASSERT = 2;

   logic        wb_clk = 1'b0;
   logic        wb_rst = 1'b1;
   logic [6:0]  evt_i = '0;
   logic [3:0]  wb_adr_i = '0;
   logic [31:0] wb_dat_i = '0;
   logic [31:0] wb_dat_o;
   logic        wb_we_i = 1'b0;
   logic        wb_stb_i = 1'b0;
   logic        wb_cyc_i = 1'b0;
   logic        wb_ack_o;
   logic        wb_intr;

   int n_total = 0;
   int n_bad   = 0;

   // Model state
   int unsigned m_pend = 0, m_mask = 0, m_thresh = 1, m_tmo = 0;
   int unsigned m_cnt = 0, m_timer = 0, m_st = S_IDLE, m_prev = 0, m_rdat = 0;
   bit          m_ack = 0, m_intr = 0;

   always #5 wb_clk = ~wb_clk;

   eth_intr_coalesce_ctrl #(
      .NSRC  (7),
      .CNT_W (8),
      .TMO_W (16)
   ) dut (
      .wb_clk   (wb_clk),
      .wb_rst   (wb_rst),
      .evt_i    (evt_i),
      .wb_adr_i (wb_adr_i),
      .wb_dat_i (wb_dat_i),
      .wb_dat_o (wb_dat_o),
      .wb_we_i  (wb_we_i),
      .wb_stb_i (wb_stb_i),
      .wb_cyc_i (wb_cyc_i),
      .wb_ack_o (wb_ack_o),
      .wb_intr  (wb_intr)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic int unsigned m_read(input logic [1:0] a);
      case (a)
         2'd0:    return m_pend;
         2'd1:    return m_mask;
         2'd2:    return m_thresh | (m_tmo << 8);
         default: return (m_st << 16) | m_cnt;
      endcase
   endfunction

   // One clock of the controller's rules, evaluated on the inputs seen at the edge
   task automatic model_step();
      int unsigned newv, w1c, nst, ncnt, ntimer;
      bit          active, req, wr;
      if (wb_rst) begin
         m_pend = 0; m_mask = 0; m_thresh = 1; m_tmo = 0; m_cnt = 0; m_timer = 0;
         m_st = S_IDLE; m_prev = 0; m_ack = 0; m_intr = 0; m_rdat = 0;
         return;
      end
      newv   = 32'(evt_i) & ~m_prev;
      req    = wb_cyc_i && wb_stb_i && !m_ack;
      wr     = wb_cyc_i && wb_stb_i && wb_we_i && m_ack;
      w1c    = (wr && wb_adr_i[3:2] == 2'd0) ? (wb_dat_i & 32'h7F) : 0;
      active = (m_pend & m_mask) != 0;
      nst    = m_st;
      if (m_st == S_IDLE) begin
         if (active) nst = S_ACCUM;
      end else if (m_st == S_ACCUM) begin
         if (!active) nst = S_IDLE;
         else if (m_thresh <= 1 || m_cnt >= m_thresh || (m_tmo != 0 && m_timer == 1))
            nst = S_ASSERT;
      end else begin
         if (!active) nst = S_IDLE;
      end
      if (m_st != S_IDLE && nst == S_IDLE) begin
         ncnt = 0;
      end else begin
         ncnt = m_cnt + $countones(newv & m_mask);
         if (ncnt > 255) ncnt = 255;
      end
      if (m_st == S_IDLE && nst == S_ACCUM) ntimer = m_tmo;
      else if (m_st == S_ACCUM && m_timer != 0) ntimer = m_timer - 1;
      else ntimer = m_timer;
      if (req) m_rdat = m_read(wb_adr_i[3:2]);
      if (wr && wb_adr_i[3:2] == 2'd1) m_mask = wb_dat_i & 32'h7F;
      if (wr && wb_adr_i[3:2] == 2'd2) begin
         m_thresh = wb_dat_i & 32'hFF;
         m_tmo    = (wb_dat_i >> 8) & 32'hFFFF;
      end
      m_pend  = (m_pend & ~w1c) | newv;
      m_intr  = (m_st == S_ASSERT);
      m_ack   = req;
      m_st    = nst;
      m_cnt   = ncnt;
      m_timer = ntimer;
      m_prev  = 32'(evt_i);
   endtask

   task automatic tick();
      @(posedge wb_clk);
      model_step();
      @(negedge wb_clk);
      check("intr", 32'(wb_intr), 32'(m_intr));
      check("ack", 32'(wb_ack_o), 32'(m_ack));
      if (m_ack) check("rdata", wb_dat_o, m_rdat);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic wb_write(input logic [3:0] a, input logic [31:0] d,
                           input bit ev_on_ack = 1'b0, input logic [6:0] ev = '0);
      int n = 0;
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = a; wb_dat_i = d;
      do begin tick(); n++; end while (!wb_ack_o && n < 8);
      check("wr_ack_seen", 32'(wb_ack_o), 32'd1);
      if (ev_on_ack) evt_i = ev;
      tick();
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
   endtask

   task automatic wb_read(input logic [3:0] a, output logic [31:0] d);
      int n = 0;
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = a;
      do begin tick(); n++; end while (!wb_ack_o && n < 8);
      check("rd_ack_seen", 32'(wb_ack_o), 32'd1);
      d = wb_dat_o;
      tick();
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
   endtask

   task automatic pulse(input logic [6:0] b);
      evt_i = b;
      tick();
      evt_i = '0;
      tick();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      bit          busy, done;

      // 1. reset state and basic latency
      ticks(3);
      check("rst_intr", 32'(wb_intr), 32'd0);
      check("rst_ack", 32'(wb_ack_o), 32'd0);
      check("rst_dato", wb_dat_o, 32'd0);
      wb_rst = 1'b0;
      tick();
      wb_read(4'h0, rd); check("rst_pend", rd, 32'h0);
      wb_read(4'h4, rd); check("rst_mask", rd, 32'h0);
      wb_read(4'h8, rd); check("rst_coal", rd, 32'h1);
      wb_read(4'hC, rd); check("rst_stat", rd, 32'h0);
      wb_write(4'h4, 32'h7F);
      evt_i = 7'h01;
      for (int i = 1; i <= 4; i++) begin
         tick();
         evt_i = '0;
         check("t1_latency", 32'(wb_intr), 32'(i == 4));
      end
      wb_read(4'h0, rd); check("t1_pend", rd, 32'h01);
      wb_write(4'h0, 32'h01);
      ticks(3);
      check("t1_intr_drop", 32'(wb_intr), 32'd0);
      wb_read(4'hC, rd); check("t1_stat_idle", rd, 32'h0);

      // 2. count threshold of 3
      wb_write(4'h8, 32'h3);
      pulse(7'h02); ticks(2);
      pulse(7'h04); ticks(2);
      check("t2_no_intr", 32'(wb_intr), 32'd0);
      wb_read(4'hC, rd); check("t2_stat", rd, 32'h0001_0002);
      pulse(7'h08); ticks(2);
      check("t2_intr", 32'(wb_intr), 32'd1);
      wb_write(4'h0, 32'h7F); ticks(3);
      check("t2_clear", 32'(wb_intr), 32'd0);

      // 3. timeout of 20 with threshold 8
      wb_write(4'h8, (32'd20 << 8) | 32'd8);
      evt_i = 7'h01;
      for (int i = 1; i <= 24; i++) begin
         tick();
         evt_i = '0;
         check("t3_timeout", 32'(wb_intr), 32'(i >= 23));
      end
      wb_read(4'hC, rd); check("t3_stat", rd, 32'h0002_0001);
      wb_write(4'h0, 32'h7F); ticks(3);

      // 4. masked event, then unmask
      wb_write(4'h8, 32'h1);
      wb_write(4'h4, 32'h0);
      pulse(7'h10); ticks(3);
      check("t4_masked", 32'(wb_intr), 32'd0);
      wb_read(4'h0, rd); check("t4_pend", rd, 32'h10);
      wb_read(4'hC, rd); check("t4_stat_idle", rd, 32'h0);
      wb_write(4'h4, 32'h10);
      for (int i = 1; i <= 3; i++) begin
         tick();
         check("t4_unmask", 32'(wb_intr), 32'(i == 3));
      end
      wb_read(4'hC, rd); check("t4_stat", rd, 32'h0002_0000);
      wb_write(4'h0, 32'h10); ticks(3);
      check("t4_clear", 32'(wb_intr), 32'd0);

      // 5. W1C racing a new edge on the same bit
      wb_write(4'h4, 32'h7F);
      pulse(7'h04); ticks(2);
      check("t5_intr", 32'(wb_intr), 32'd1);
      wb_write(4'h0, 32'h04, 1'b1, 7'h04);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t5_hold", 32'(wb_intr), 32'd1);
      end
      wb_read(4'h0, rd); check("t5_pend", rd, 32'h04);
      evt_i = '0;
      wb_write(4'h0, 32'h04); ticks(3);
      check("t5_clear", 32'(wb_intr), 32'd0);

      // 6. reset during ASSERT with a read outstanding
      pulse(7'h01); ticks(2);
      check("t6_intr", 32'(wb_intr), 32'd1);
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 4'hC; wb_rst = 1'b1;
      tick();
      check("t6_noack", 32'(wb_ack_o), 32'd0);
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
      tick();
      wb_rst = 1'b0;
      tick();
      check("t6_intr_low", 32'(wb_intr), 32'd0);
      check("t6_noack2", 32'(wb_ack_o), 32'd0);
      wb_read(4'h4, rd); check("t6_mask", rd, 32'h0);
      wb_read(4'h8, rd); check("t6_coal", rd, 32'h1);
      wb_read(4'h0, rd); check("t6_pend", rd, 32'h0);
      wb_read(4'hC, rd); check("t6_stat", rd, 32'h0);

      // Randomized traffic against the model
      busy = 0; done = 0;
      for (int c = 0; c < 3000; c++) begin
         for (int b = 0; b < 7; b++) begin
            if ($urandom_range(0, 9) == 0) evt_i[b] = ~evt_i[b];
         end
         if (busy && done) begin
            wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
            busy = 0; done = 0;
         end else if (busy && wb_ack_o) begin
            done = 1;
         end else if (!busy && $urandom_range(0, 3) == 0) begin
            busy     = 1;
            wb_cyc_i = 1'b1;
            wb_stb_i = 1'b1;
            wb_we_i  = 1'($urandom_range(0, 1));
            wb_adr_i = {2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            if (wb_adr_i[3:2] == 2'd2 && $urandom_range(0, 7) != 0)
               wb_dat_i = ($urandom_range(0, 30) << 8) | $urandom_range(0, 5);
            else
               wb_dat_i = $urandom;
         end
         if ($urandom_range(0, 499) == 0) begin
            wb_rst   = 1'b1;
            wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
            busy = 0; done = 0;
         end else begin
            wb_rst = 1'b0;
         end
         tick();
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
